// File: rtl/fprint_compare_engine_pkg.sv
// Shared fingerprint-checker constants and the compare FSM encodings used by
// the compare engine and its pointer bank.
package fprint_compare_engine_pkg;

    localparam int CRC_KEY_WIDTH         = 4;
    localparam int CRC_KEY_SIZE          = 1 << CRC_KEY_WIDTH;
    localparam int CRC_RAM_ADDRESS_WIDTH = 8;
    localparam int CRC_WIDTH             = 32;

    localparam logic [2:0] CMP_IDLE   = 3'd0;
    localparam logic [2:0] CMP_SETUP  = 3'd1;
    localparam logic [2:0] CMP_READ   = 3'd2;
    localparam logic [2:0] CMP_CMP    = 3'd3;
    localparam logic [2:0] CMP_RETIRE = 3'd4;

endpackage

// File: rtl/fprint_pointer_bank.sv
// Per-core head pointers, per-task tail pointers and overflow flags for the
// fingerprint RAM, with occupancy (head - tail) status per task.
module fprint_pointer_bank #(
    parameter int KEY_WIDTH  = 4,
    parameter int SLOT_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc_en,
    input  logic                  sel_core,
    input  logic [KEY_WIDTH-1:0]  sel_task,
    output logic [SLOT_WIDTH-1:0] sel_head,
    input  logic                  tail_inc_en,
    input  logic                  clr_en,
    input  logic [KEY_WIDTH-1:0]  cmp_task,
    output logic [SLOT_WIDTH-1:0] cmp_tail,
    output logic [(1<<KEY_WIDTH)-1:0] nz0,
    output logic [(1<<KEY_WIDTH)-1:0] nz1,
    output logic [(1<<KEY_WIDTH)-1:0] ovf
);
    import fprint_compare_engine_pkg::*;

    localparam int NTASK = 1 << KEY_WIDTH;
    localparam logic [SLOT_WIDTH-1:0] SLOT_ONE = SLOT_WIDTH'(1);

    logic [SLOT_WIDTH-1:0] head0 [NTASK];
    logic [SLOT_WIDTH-1:0] head1 [NTASK];
    logic [SLOT_WIDTH-1:0] tail  [NTASK];
    logic [SLOT_WIDTH-1:0] sel_cnt;
    logic                  sel_full;

    assign sel_head = sel_core ? head1[sel_task] : head0[sel_task];
    assign sel_cnt  = sel_head - tail[sel_task];
    assign sel_full = &sel_cnt;
    assign cmp_tail = tail[cmp_task];

    for (genvar i = 0; i < NTASK; i++) begin : g_cnt
        logic [SLOT_WIDTH-1:0] cnt0;
        logic [SLOT_WIDTH-1:0] cnt1;
        assign cnt0   = head0[i] - tail[i];
        assign cnt1   = head1[i] - tail[i];
        assign nz0[i] = |cnt0;
        assign nz1[i] = |cnt1;
    end

    // A store into a full task never advances the head; it flags the task instead.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NTASK; i++) begin
                head0[i] <= '0;
                head1[i] <= '0;
                tail[i]  <= '0;
            end
            ovf <= '0;
        end else begin
            if (inc_en) begin
                if (sel_full)
                    ovf[sel_task] <= 1'b1;
                else if (sel_core)
                    head1[sel_task] <= head1[sel_task] + SLOT_ONE;
                else
                    head0[sel_task] <= head0[sel_task] + SLOT_ONE;
            end
            if (tail_inc_en)
                tail[cmp_task] <= tail[cmp_task] + SLOT_ONE;
            if (clr_en) begin
                head0[cmp_task] <= '0;
                head1[cmp_task] <= '0;
                tail[cmp_task]  <= '0;
                ovf[cmp_task]   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fprint_compare_engine.sv
// Compares fingerprint streams of two logical cores per task, retires tasks
// as verified or faulty and raises a sticky mismatch interrupt.
module fprint_compare_engine #(
    parameter int KEY_WIDTH      = fprint_compare_engine_pkg::CRC_KEY_WIDTH,
    parameter int RAM_ADDR_WIDTH = fprint_compare_engine_pkg::CRC_RAM_ADDRESS_WIDTH,
    parameter int CRC_WIDTH      = fprint_compare_engine_pkg::CRC_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        logical_core_id,
    input  logic [KEY_WIDTH-1:0]        fprint_task_id,
    input  logic                        increment_head_pointer,
    output logic                        increment_hp_ack,
    output logic [RAM_ADDR_WIDTH-1:0]   fprint_head_pointer,
    input  logic [(1<<KEY_WIDTH)-1:0]   checkin_reg_out,
    output logic [RAM_ADDR_WIDTH-1:0]   comp_tail_pointer0,
    output logic [RAM_ADDR_WIDTH-1:0]   comp_tail_pointer1,
    input  logic [CRC_WIDTH-1:0]        fprint0,
    input  logic [CRC_WIDTH-1:0]        fprint1,
    output logic                        comp_task_verified,
    output logic [KEY_WIDTH-1:0]        comp_task,
    input  logic                        fprint_reg_ack,
    output logic                        mismatch_irq,
    output logic [KEY_WIDTH-1:0]        mismatch_task,
    input  logic                        irq_clear
);
    import fprint_compare_engine_pkg::*;

    localparam int NTASK      = 1 << KEY_WIDTH;
    localparam int SLOT_WIDTH = RAM_ADDR_WIDTH - KEY_WIDTH;
    localparam logic [KEY_WIDTH-1:0] KEY_ONE = KEY_WIDTH'(1);

    logic [2:0]            state;
    logic [KEY_WIDTH-1:0]  cur_task;
    logic [KEY_WIDTH-1:0]  rr;
    logic [KEY_WIDTH-1:0]  pick;
    logic                  pick_vld;
    logic                  pick_fault;
    logic [2:0]            pick_state;
    logic [NTASK-1:0]      nz0;
    logic [NTASK-1:0]      nz1;
    logic [NTASK-1:0]      ovf;
    logic [NTASK-1:0]      elig;
    logic [SLOT_WIDTH-1:0] sel_head;
    logic [SLOT_WIDTH-1:0] cmp_tail;
    logic                  accept;
    logic                  tail_inc;
    logic                  clr;
    logic                  fprint_match;
    logic                  fault_set;
    logic [KEY_WIDTH-1:0]  fault_task;
    logic                  rd_active;

    fprint_pointer_bank #(
        .KEY_WIDTH  (KEY_WIDTH),
        .SLOT_WIDTH (SLOT_WIDTH)
    ) u_bank (
        .clk         (clk),
        .reset       (reset),
        .inc_en      (accept),
        .sel_core    (logical_core_id),
        .sel_task    (fprint_task_id),
        .sel_head    (sel_head),
        .tail_inc_en (tail_inc),
        .clr_en      (clr),
        .cmp_task    (cur_task),
        .cmp_tail    (cmp_tail),
        .nz0         (nz0),
        .nz1         (nz1),
        .ovf         (ovf)
    );

    // The requester holds its level request until it sees the ack, so a request
    // that is still high while the ack is out must not be counted twice.
    assign accept = increment_head_pointer & ~increment_hp_ack &
                    ~((state == CMP_RETIRE) & (cur_task == fprint_task_id));

    assign fprint_head_pointer = {fprint_task_id, sel_head};
    assign elig                = ovf | (nz0 & nz1) | checkin_reg_out;
    assign fprint_match        = (fprint0 == fprint1);
    assign tail_inc            = (state == CMP_CMP) & fprint_match;
    assign clr                 = (state == CMP_RETIRE) & fprint_reg_ack;

    // Round-robin arbiter: lowest offset from rr wins, so it is applied last.
    always_comb begin
        pick_vld = 1'b0;
        pick     = rr;
        for (int i = NTASK - 1; i >= 0; i--) begin
            if (elig[rr + KEY_WIDTH'(i)]) begin
                pick_vld = 1'b1;
                pick     = rr + KEY_WIDTH'(i);
            end
        end
    end

    always_comb begin
        pick_fault = 1'b0;
        pick_state = CMP_RETIRE;
        if (ovf[pick])
            pick_fault = 1'b1;
        else if (nz0[pick] & nz1[pick])
            pick_state = CMP_SETUP;
        else if (nz0[pick] ^ nz1[pick])
            pick_fault = 1'b1;
    end

    assign fault_set  = ((state == CMP_IDLE) & pick_vld & pick_fault) |
                        ((state == CMP_CMP) & ~fprint_match);
    assign fault_task = (state == CMP_IDLE) ? pick : cur_task;

    // SETUP presents the address, READ covers RAM latency, CMP sees the data.
    assign rd_active          = (state == CMP_SETUP) | (state == CMP_READ) | (state == CMP_CMP);
    assign comp_tail_pointer0 = rd_active ? {cur_task, cmp_tail} : '0;
    assign comp_tail_pointer1 = rd_active ? {cur_task, cmp_tail} : '0;
    assign comp_task_verified = (state == CMP_RETIRE);
    assign comp_task          = (state == CMP_RETIRE) ? cur_task : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= CMP_IDLE;
            cur_task         <= '0;
            rr               <= '0;
            increment_hp_ack <= 1'b0;
            mismatch_irq     <= 1'b0;
            mismatch_task    <= '0;
        end else begin
            increment_hp_ack <= accept;
            case (state)
                CMP_IDLE: begin
                    if (pick_vld) begin
                        cur_task <= pick;
                        rr       <= pick + KEY_ONE;
                        state    <= pick_state;
                    end
                end
                CMP_SETUP: state <= CMP_READ;
                CMP_READ:  state <= CMP_CMP;
                CMP_CMP:   state <= fprint_match ? CMP_IDLE : CMP_RETIRE;
                CMP_RETIRE: begin
                    if (fprint_reg_ack)
                        state <= CMP_IDLE;
                end
                default: state <= CMP_IDLE;
            endcase
            // Only the first fault since the last clear is recorded as the culprit.
            if (fault_set) begin
                mismatch_irq <= 1'b1;
                if (!mismatch_irq)
                    mismatch_task <= fault_task;
            end else if (irq_clear) begin
                mismatch_irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fprint_compare_engine.sv
// Directed bench for fprint_compare_engine with a two-port fingerprint RAM model.
module tb_fprint_compare_engine;

    logic        clk;
    logic        reset;
    logic        logical_core_id;
    logic [3:0]  fprint_task_id;
    logic        increment_head_pointer;
    logic        increment_hp_ack;
    logic [7:0]  fprint_head_pointer;
    logic [15:0] checkin_reg_out;
    logic [7:0]  comp_tail_pointer0;
    logic [7:0]  comp_tail_pointer1;
    logic [31:0] fprint0;
    logic [31:0] fprint1;
    logic        comp_task_verified;
    logic [3:0]  comp_task;
    logic        fprint_reg_ack;
    logic        mismatch_irq;
    logic [3:0]  mismatch_task;
    logic        irq_clear;

    int checks;
    int errors;

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    logic [7:0]  addr_log [$];
    logic [7:0]  prev_addr;

    fprint_compare_engine dut (
        .clk                    (clk),
        .reset                  (reset),
        .logical_core_id        (logical_core_id),
        .fprint_task_id         (fprint_task_id),
        .increment_head_pointer (increment_head_pointer),
        .increment_hp_ack       (increment_hp_ack),
        .fprint_head_pointer    (fprint_head_pointer),
        .checkin_reg_out        (checkin_reg_out),
        .comp_tail_pointer0     (comp_tail_pointer0),
        .comp_tail_pointer1     (comp_tail_pointer1),
        .fprint0                (fprint0),
        .fprint1                (fprint1),
        .comp_task_verified     (comp_task_verified),
        .comp_task              (comp_task),
        .fprint_reg_ack         (fprint_reg_ack),
        .mismatch_irq           (mismatch_irq),
        .mismatch_task          (mismatch_task),
        .irq_clear              (irq_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        fprint0 <= mem0[comp_tail_pointer0];
        fprint1 <= mem1[comp_tail_pointer1];
    end

    // Records each new nonzero core-0 read address, i.e. each compare started.
    always @(negedge clk) begin
        if (comp_tail_pointer0 != prev_addr && comp_tail_pointer0 != 8'h00)
            addr_log.push_back(comp_tail_pointer0);
        prev_addr <= comp_tail_pointer0;
    end

    function automatic logic [31:0] log_word();
        logic [31:0] w;
        w = 32'h0;
        foreach (addr_log[i]) w = (w << 8) | {24'h0, addr_log[i]};
        return w;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        logical_core_id = 1'b0;
        fprint_task_id = 4'h0;
        increment_head_pointer = 1'b0;
        checkin_reg_out = 16'h0;
        fprint_reg_ack = 1'b0;
        irq_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        addr_log.delete();
    endtask

    task automatic store(input logic c, input logic [3:0] t, input logic [3:0] s, input logic [31:0] d);
        int n;
        if (c) mem1[{t, s}] = d;
        else   mem0[{t, s}] = d;
        logical_core_id = c;
        fprint_task_id = t;
        increment_head_pointer = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (increment_hp_ack !== 1'b1 && n < 40);
        increment_head_pointer = 1'b0;
        checks++;
        if (increment_hp_ack !== 1'b1) begin
            errors++;
            $display("FAIL store_ack core=%0d task=%0d: ack=%b expected 1", c, t, increment_hp_ack);
        end
    endtask

    task automatic wait_retire(input logic [3:0] exp_task, input string name);
        int n;
        n = 0;
        while (comp_task_verified !== 1'b1 && n < 80) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (comp_task_verified !== 1'b1 || comp_task !== exp_task) begin
            errors++;
            $display("FAIL %s retire: verified=%b task=%0d expected verified=1 task=%0d",
                     name, comp_task_verified, comp_task, exp_task);
        end
    endtask

    task automatic pulse_ack(input logic [15:0] new_checkin);
        fprint_reg_ack = 1'b1;
        checkin_reg_out = new_checkin;
        @(posedge clk);
        #1;
        fprint_reg_ack = 1'b0;
    endtask

    task automatic probe_head(input logic c, input logic [3:0] t, output logic [7:0] v);
        logical_core_id = c;
        fprint_task_id = t;
        #1;
        v = fprint_head_pointer;
    endtask

    task automatic test_reset();
        logic [7:0] hp;
        reset = 1'b1;
        logical_core_id = 1'b0;
        fprint_task_id = 4'h0;
        increment_head_pointer = 1'b0;
        checkin_reg_out = 16'h0;
        fprint_reg_ack = 1'b0;
        irq_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({increment_hp_ack, comp_task_verified, comp_task, mismatch_irq, mismatch_task,
             comp_tail_pointer0, comp_tail_pointer1} !== 27'h0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b ver=%b task=%0d irq=%b mtask=%0d tp0=%0h tp1=%0h expected all 0",
                     increment_hp_ack, comp_task_verified, comp_task, mismatch_irq, mismatch_task,
                     comp_tail_pointer0, comp_tail_pointer1);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        probe_head(1'b1, 4'hA, hp);
        checks++;
        if (hp !== 8'hA0) begin
            errors++;
            $display("FAIL reset_head: got %0h expected a0", hp);
        end
        checks++;
        if (comp_task_verified !== 1'b0 || mismatch_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: ver=%b irq=%b expected 0 0", comp_task_verified, mismatch_irq);
        end
    endtask

    task automatic test_match();
        logic [7:0] hp;
        do_reset();
        for (int s = 0; s < 3; s++) store(1'b0, 4'h2, 4'(s), 32'hA5A50000 + 32'(s));
        for (int s = 0; s < 3; s++) store(1'b1, 4'h2, 4'(s), 32'hA5A50000 + 32'(s));
        checkin_reg_out = 16'h0004;
        wait_retire(4'h2, "match");
        checks++;
        if (mismatch_irq !== 1'b0) begin
            errors++;
            $display("FAIL match_irq: got %b expected 0", mismatch_irq);
        end
        checks++;
        if (addr_log.size() != 3 || log_word() !== 32'h00202122) begin
            errors++;
            $display("FAIL match_compares: got n=%0d %0h expected n=3 00202122", addr_log.size(), log_word());
        end
        pulse_ack(16'h0);
        checks++;
        if (comp_task_verified !== 1'b0) begin
            errors++;
            $display("FAIL match_release: verified=%b expected 0", comp_task_verified);
        end
        probe_head(1'b0, 4'h2, hp);
        checks++;
        if (hp !== 8'h20) begin
            errors++;
            $display("FAIL match_head0_cleared: got %0h expected 20", hp);
        end
        probe_head(1'b1, 4'h2, hp);
        checks++;
        if (hp !== 8'h20) begin
            errors++;
            $display("FAIL match_head1_cleared: got %0h expected 20", hp);
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        store(1'b0, 4'h5, 4'h0, 32'hDEADBEEF);
        store(1'b1, 4'h5, 4'h0, 32'hDEADBEEE);
        wait_retire(4'h5, "mismatch");
        checks++;
        if (mismatch_irq !== 1'b1 || mismatch_task !== 4'h5) begin
            errors++;
            $display("FAIL mismatch_flag: irq=%b task=%0d expected 1 5", mismatch_irq, mismatch_task);
        end
        pulse_ack(16'h0);
        store(1'b0, 4'h7, 4'h0, 32'h12345678);
        checkin_reg_out = 16'h0080;
        wait_retire(4'h7, "second_fault");
        checks++;
        if (mismatch_irq !== 1'b1 || mismatch_task !== 4'h5) begin
            errors++;
            $display("FAIL second_fault_keeps_first: irq=%b task=%0d expected 1 5", mismatch_irq, mismatch_task);
        end
        pulse_ack(16'h0);
        irq_clear = 1'b1;
        @(posedge clk);
        #1;
        irq_clear = 1'b0;
        checks++;
        if (mismatch_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: got %b expected 0", mismatch_irq);
        end
    endtask

    task automatic test_length_mismatch();
        do_reset();
        store(1'b0, 4'h4, 4'h0, 32'h11111111);
        store(1'b0, 4'h4, 4'h1, 32'h22222222);
        store(1'b1, 4'h4, 4'h0, 32'h11111111);
        repeat (8) @(posedge clk);
        #1;
        checkin_reg_out = 16'h0010;
        wait_retire(4'h4, "length");
        checks++;
        if (mismatch_irq !== 1'b1 || mismatch_task !== 4'h4) begin
            errors++;
            $display("FAIL length_fault: irq=%b task=%0d expected 1 4", mismatch_irq, mismatch_task);
        end
        checks++;
        if (addr_log.size() != 1 || log_word() !== 32'h00000040) begin
            errors++;
            $display("FAIL length_compares: got n=%0d %0h expected n=1 40", addr_log.size(), log_word());
        end
        pulse_ack(16'h0);
    endtask

    task automatic test_overflow();
        logic [7:0] hp;
        do_reset();
        for (int s = 0; s < 15; s++) store(1'b0, 4'h6, 4'(s), 32'h600 + 32'(s));
        probe_head(1'b0, 4'h6, hp);
        checks++;
        if (hp !== 8'h6F || comp_task_verified !== 1'b0) begin
            errors++;
            $display("FAIL overflow_full: head=%0h ver=%b expected 6f 0", hp, comp_task_verified);
        end
        store(1'b0, 4'h6, 4'hF, 32'h60F);
        probe_head(1'b0, 4'h6, hp);
        checks++;
        if (hp !== 8'h6F) begin
            errors++;
            $display("FAIL overflow_saturate: head=%0h expected 6f", hp);
        end
        wait_retire(4'h6, "overflow");
        checks++;
        if (mismatch_irq !== 1'b1 || mismatch_task !== 4'h6) begin
            errors++;
            $display("FAIL overflow_fault: irq=%b task=%0d expected 1 6", mismatch_irq, mismatch_task);
        end
        pulse_ack(16'h0);
        probe_head(1'b0, 4'h6, hp);
        checks++;
        if (hp !== 8'h60) begin
            errors++;
            $display("FAIL overflow_cleared: head=%0h expected 60", hp);
        end
    endtask

    task automatic test_concurrent_cmp();
        logic [7:0] hp;
        do_reset();
        store(1'b0, 4'h3, 4'h0, 32'hCAFE0000);
        store(1'b1, 4'h3, 4'h0, 32'hCAFE0000);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (comp_tail_pointer0 !== 8'h30 || comp_tail_pointer1 !== 8'h30) begin
            errors++;
            $display("FAIL concurrent_in_cmp: tp0=%0h tp1=%0h expected 30 30", comp_tail_pointer0, comp_tail_pointer1);
        end
        mem0[8'h31] = 32'hCAFE0001;
        logical_core_id = 1'b0;
        fprint_task_id = 4'h3;
        increment_head_pointer = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (increment_hp_ack !== 1'b1) begin
            errors++;
            $display("FAIL concurrent_ack_latency: ack=%b expected 1", increment_hp_ack);
        end
        increment_head_pointer = 1'b0;
        probe_head(1'b0, 4'h3, hp);
        checks++;
        if (hp !== 8'h32) begin
            errors++;
            $display("FAIL concurrent_head: got %0h expected 32", hp);
        end
        store(1'b1, 4'h3, 4'h1, 32'hCAFE0001);
        repeat (8) @(posedge clk);
        #1;
        checkin_reg_out = 16'h0008;
        wait_retire(4'h3, "concurrent");
        checks++;
        if (mismatch_irq !== 1'b0 || addr_log.size() != 2 || log_word() !== 32'h00003031) begin
            errors++;
            $display("FAIL concurrent_compares: irq=%b n=%0d %0h expected 0 n=2 3031",
                     mismatch_irq, addr_log.size(), log_word());
        end
        pulse_ack(16'h0);
    endtask

    task automatic test_retire_stall();
        logic [7:0] hp;
        int n_ack;
        do_reset();
        checkin_reg_out = 16'h0002;
        wait_retire(4'h1, "stall");
        mem0[8'h10] = 32'h10101010;
        logical_core_id = 1'b0;
        fprint_task_id = 4'h1;
        increment_head_pointer = 1'b1;
        n_ack = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (increment_hp_ack === 1'b1) n_ack++;
        end
        checks++;
        if (n_ack != 0 || comp_task_verified !== 1'b1) begin
            errors++;
            $display("FAIL stall_no_ack: acks=%0d ver=%b expected 0 1", n_ack, comp_task_verified);
        end
        pulse_ack(16'h0);
        checks++;
        if (increment_hp_ack !== 1'b0) begin
            errors++;
            $display("FAIL stall_ack_edge: ack=%b expected 0", increment_hp_ack);
        end
        @(posedge clk);
        #1;
        checks++;
        if (increment_hp_ack !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ack: ack=%b expected 1", increment_hp_ack);
        end
        increment_head_pointer = 1'b0;
        probe_head(1'b0, 4'h1, hp);
        checks++;
        if (hp !== 8'h11) begin
            errors++;
            $display("FAIL stall_head: got %0h expected 11", hp);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        store(1'b0, 4'h0, 4'h0, 32'h00000AAA);
        store(1'b1, 4'h0, 4'h0, 32'h00000AAA);
        repeat (8) @(posedge clk);
        #1;
        checkin_reg_out = 16'h0200;
        wait_retire(4'h9, "rr_hold");
        store(1'b0, 4'h0, 4'h1, 32'h0001);
        store(1'b0, 4'h0, 4'h2, 32'h0002);
        store(1'b0, 4'hF, 4'h0, 32'hF000);
        store(1'b0, 4'hF, 4'h1, 32'hF001);
        store(1'b1, 4'h0, 4'h1, 32'h0001);
        store(1'b1, 4'h0, 4'h2, 32'h0002);
        store(1'b1, 4'hF, 4'h0, 32'hF000);
        store(1'b1, 4'hF, 4'h1, 32'hF001);
        addr_log.delete();
        pulse_ack(16'h0);
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (addr_log.size() != 4 || log_word() !== 32'hF001F102) begin
            errors++;
            $display("FAIL round_robin_order: got n=%0d %0h expected n=4 f001f102", addr_log.size(), log_word());
        end
        checks++;
        if (mismatch_irq !== 1'b0 || comp_task_verified !== 1'b0) begin
            errors++;
            $display("FAIL round_robin_clean: irq=%b ver=%b expected 0 0", mismatch_irq, comp_task_verified);
        end
    endtask

    task automatic test_reset_in_retire();
        logic [7:0] hp;
        do_reset();
        store(1'b0, 4'h2, 4'h0, 32'h2);
        store(1'b0, 4'h8, 4'h0, 32'h8);
        checkin_reg_out = 16'h0100;
        wait_retire(4'h8, "reset_retire");
        checks++;
        if (mismatch_irq !== 1'b1 || mismatch_task !== 4'h8) begin
            errors++;
            $display("FAIL reset_retire_fault: irq=%b task=%0d expected 1 8", mismatch_irq, mismatch_task);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({comp_task_verified, comp_task, mismatch_irq, mismatch_task, increment_hp_ack,
             comp_tail_pointer0} !== 19'h0) begin
            errors++;
            $display("FAIL reset_retire_outputs: ver=%b task=%0d irq=%b mtask=%0d ack=%b tp0=%0h expected all 0",
                     comp_task_verified, comp_task, mismatch_irq, mismatch_task, increment_hp_ack, comp_tail_pointer0);
        end
        checkin_reg_out = 16'h0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        probe_head(1'b0, 4'h2, hp);
        checks++;
        if (hp !== 8'h20) begin
            errors++;
            $display("FAIL reset_retire_head2: got %0h expected 20", hp);
        end
        probe_head(1'b0, 4'h8, hp);
        checks++;
        if (hp !== 8'h80) begin
            errors++;
            $display("FAIL reset_retire_head8: got %0h expected 80", hp);
        end
        @(posedge clk);
        #1;
        checks++;
        if (comp_task_verified !== 1'b0) begin
            errors++;
            $display("FAIL reset_retire_abandoned: ver=%b expected 0", comp_task_verified);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 32'h0;
            mem1[i] = 32'h0;
        end
        test_reset();
        test_match();
        test_mismatch();
        test_length_mismatch();
        test_overflow();
        test_concurrent_cmp();
        test_retire_stall();
        test_round_robin();
        test_reset_in_retire();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
